// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg
// Shared definitions for the AXI4-Stream packet FIFO:
//   - default stream geometry (32-bit tdata, 4-bit tkeep, 16 entries)
//   - axis_beat_t : one stored beat {data, keep, last} at the default width
//   - beat_width(): packed width of a stored beat for any tdata width
//   - clog2_cnt() : width of a counter that must hold 0..depth inclusive
package axis_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int DEF_DEPTH      = 16;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_KEEP_WIDTH-1:0] keep;
    logic                      last;
  } axis_beat_t;

  // Stored beat layout is {data, keep, last}; last sits in bit 0.
  function automatic int beat_width(input int data_width);
    return data_width + (data_width / 8) + 1;
  endfunction

  // A full FIFO holds exactly depth beats, so counters need one extra code.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem
// Beat storage for axis_pkt_fifo: DEPTH x WIDTH array, synchronous write,
// asynchronous (combinational) read, no reset on the contents.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : beat to store
//   raddr : read address
//   rdata : beat currently stored at raddr
module axis_fifo_mem #(
  parameter int WIDTH  = 37,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
// AXI4-Stream FIFO with optional store-and-forward operation. In packet
// mode a packet is released only once its tlast beat is stored; a packet
// larger than the buffer switches to cut-through (bypass) and raises a
// sticky oversize_err so the FIFO can never deadlock.
// Ports:
//   axi_aclk, axi_reset      : clock, asynchronous active-high reset
//   s_axis_t{data,keep,valid,last} / s_axis_tready : input stream
//   m_axis_t{data,keep,valid,last} / m_axis_tready : output stream
//   occupancy                : beats currently stored
//   pkt_count                : complete packets (stored tlast beats)
//   oversize_err             : sticky, packet exceeded DEPTH in packet mode
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int  DEPTH       = DEF_DEPTH,
  parameter int  PACKET_MODE = 0,
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8,
  localparam int CNT_W       = clog2_cnt(DEPTH)
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_W-1:0]      occupancy,
  output logic [CNT_W-1:0]      pkt_count,
  output logic                  oversize_err
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               BEAT_W   = beat_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;
  logic              s_rdy_q, s_rdy_d;
  logic              byp_q, byp_d;
  logic              err_q, err_d;

  logic              wr_en, rd_en;
  logic              wr_pkt, rd_pkt;
  logic              m_valid;
  logic [BEAT_W-1:0] wr_beat, rd_beat;

  assign wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

  axis_fifo_mem #(
    .WIDTH  (BEAT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (axi_aclk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_beat),
    .raddr (rd_ptr_q),
    .rdata (rd_beat)
  );

  // Valid depends only on registered state, so once raised it cannot drop
  // until the head beat is taken.
  always_comb begin
    if (PACKET_MODE != 0) begin
      m_valid = (occ_q != '0) && ((pkt_q != '0) || byp_q);
    end else begin
      m_valid = (occ_q != '0);
    end
  end

  assign wr_en  = s_axis_tvalid && s_rdy_q;
  assign rd_en  = m_valid && m_axis_tready;
  assign wr_pkt = wr_en && s_axis_tlast;
  assign rd_pkt = rd_en && rd_beat[0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    byp_d    = byp_q;
    err_d    = err_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case ({wr_pkt, rd_pkt})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    // A full buffer with no complete packet can never release anything in
    // store-and-forward mode: drain the current packet as cut-through.
    if ((PACKET_MODE != 0) && (occ_q == FULL_CNT) && (pkt_q == '0)) begin
      byp_d = 1'b1;
      err_d = 1'b1;
    end
    if (rd_pkt) byp_d = 1'b0;

    // Registered ready: a read in the full cycle frees the slot next cycle.
    s_rdy_d = (occ_d < FULL_CNT);
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      s_rdy_q  <= 1'b0;
      byp_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      s_rdy_q  <= s_rdy_d;
      byp_q    <= byp_d;
      err_q    <= err_d;
    end
  end

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = m_valid;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = rd_beat;
  assign occupancy     = occ_q;
  assign pkt_count     = pkt_q;
  assign oversize_err  = err_q;

endmodule
